// File: rtl/vram_rect_fill_if.sv
// vram_rect_fill_if: fill-command handshake plus VRAM write port and status
interface vram_rect_fill_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_x0;
  logic [6:0]  cmd_y0;
  logic [6:0]  cmd_x1;
  logic [6:0]  cmd_y1;
  logic [3:0]  cmd_r;
  logic [3:0]  cmd_g;
  logic [3:0]  cmd_b;
  logic [11:0] hCoordW;
  logic [10:0] vCoordW;
  logic [3:0]  dataR;
  logic [3:0]  dataG;
  logic [3:0]  dataB;
  logic        wEn;
  logic        busy;
  logic        done;
  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_r, cmd_g, cmd_b,
    input  cmd_ready, hCoordW, vCoordW, dataR, dataG, dataB, wEn, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_r, cmd_g, cmd_b,
    output cmd_ready, hCoordW, vCoordW, dataR, dataG, dataB, wEn, busy, done
  );
endinterface

// File: rtl/vram_rect_fill.sv
// vram_rect_fill: turns cell-rectangle fill commands into one raster-order VRAM pixel write per clock
module vram_rect_fill #(
  parameter int COLS       = 100,
  parameter int ROWS       = 75,
  parameter int CELL_SHIFT = 3
) (
  input logic            clk,
  input logic            reset,
  vram_rect_fill_if.slave bus
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t     state, stateNext;
  logic [6:0] curX, curY, x0, x1, y1, clipX1, clipY1;
  logic [6:0] curXNext, curYNext, x0Next, x1Next, y1Next;
  logic [3:0] colR, colG, colB, colRNext, colGNext, colBNext;
  logic       done, doneNext, empty, rowEnd;
  assign clipX1 = bus.cmd_x1 > 7'(COLS - 1) ? 7'(COLS - 1) : bus.cmd_x1;
  assign clipY1 = bus.cmd_y1 > 7'(ROWS - 1) ? 7'(ROWS - 1) : bus.cmd_y1;
  assign empty  = bus.cmd_x0 > clipX1 || bus.cmd_y0 > clipY1;
  assign rowEnd = curX == x1;
  // cur always mirrors the write on the output port; done flags that it is the last cell
  always_comb begin
    stateNext = state;
    curXNext  = curX;
    curYNext  = curY;
    x0Next    = x0;
    x1Next    = x1;
    y1Next    = y1;
    colRNext  = colR;
    colGNext  = colG;
    colBNext  = colB;
    doneNext  = 1'b0;
    if (state == IDLE) begin
      if (bus.cmd_valid) begin
        doneNext = empty;
        if (!empty) begin
          stateNext = FILL;
          curXNext  = bus.cmd_x0;
          curYNext  = bus.cmd_y0;
          x0Next    = bus.cmd_x0;
          x1Next    = clipX1;
          y1Next    = clipY1;
          colRNext  = bus.cmd_r;
          colGNext  = bus.cmd_g;
          colBNext  = bus.cmd_b;
          doneNext  = bus.cmd_x0 == clipX1 && bus.cmd_y0 == clipY1;
        end
      end
    end else if (done) begin
      stateNext = IDLE;
    end else begin
      curXNext = rowEnd ? x0 : curX + 7'd1;
      curYNext = rowEnd ? curY + 7'd1 : curY;
      doneNext = curXNext == x1 && curYNext == y1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      curX  <= '0;
      curY  <= '0;
      x0    <= '0;
      x1    <= '0;
      y1    <= '0;
      colR  <= '0;
      colG  <= '0;
      colB  <= '0;
      done  <= 1'b0;
    end else begin
      state <= stateNext;
      curX  <= curXNext;
      curY  <= curYNext;
      x0    <= x0Next;
      x1    <= x1Next;
      y1    <= y1Next;
      colR  <= colRNext;
      colG  <= colGNext;
      colB  <= colBNext;
      done  <= doneNext;
    end
  end
  assign bus.cmd_ready = state == IDLE;
  assign bus.busy      = state == FILL;
  assign bus.wEn       = state == FILL;
  assign bus.hCoordW   = 12'(curX) << CELL_SHIFT;
  assign bus.vCoordW   = 11'(curY) << CELL_SHIFT;
  assign bus.dataR     = colR;
  assign bus.dataG     = colG;
  assign bus.dataB     = colB;
  assign bus.done      = done;
endmodule

// File: tb/tb_vram_rect_fill.sv
// tb_vram_rect_fill: random and directed fill commands checked against a rectangle-walk model
module tb_vram_rect_fill;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int lastH = 0, lastV = 0;
  logic [3:0] lastR = '0, lastG = '0, lastB = '0;
  vram_rect_fill_if bus();
  vram_rect_fill dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [38:0] obs();
    return {bus.wEn, bus.busy, bus.cmd_ready, bus.hCoordW, bus.vCoordW,
            bus.dataR, bus.dataG, bus.dataB, bus.done};
  endfunction
  function automatic logic [38:0] pack(input bit w, input bit b, input bit rdy, input int px,
                                        input int py, input logic [3:0] r, input logic [3:0] g,
                                        input logic [3:0] bl, input bit d);
    return {w, b, rdy, 12'(px), 11'(py), r, g, bl, d};
  endfunction
  function automatic logic [37:0] zeroView();
    return {bus.wEn, bus.busy, bus.hCoordW, bus.vCoordW, bus.dataR, bus.dataG, bus.dataB, bus.done};
  endfunction
  task automatic acceptCmd(input int ax0, input int ay0, input int ax1, input int ay1,
                           input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                           input bit keep);
    @(negedge clk);
    bus.cmd_x0 = 7'(ax0);
    bus.cmd_y0 = 7'(ay0);
    bus.cmd_x1 = 7'(ax1);
    bus.cmd_y1 = 7'(ay1);
    bus.cmd_r = r;
    bus.cmd_g = g;
    bus.cmd_b = b;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 20000 && !bus.cmd_ready; i++) @(negedge clk);
    if (!bus.cmd_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) bus.cmd_valid = 1'b0;
  endtask
  // Walks the clipped rectangle row by row and expects one write per cycle
  task automatic expectCmd(input string tag, input int ax0, input int ay0, input int ax1,
                           input int ay1, input logic [3:0] r, input logic [3:0] g,
                           input logic [3:0] b);
    int cx1, cy1;
    cx1 = ax1 > 99 ? 99 : ax1;
    cy1 = ay1 > 74 ? 74 : ay1;
    if (ax0 > cx1 || ay0 > cy1) begin
      @(negedge clk);
      check({tag, "_empty_done"}, obs(), pack(0, 0, 1, lastH, lastV, lastR, lastG, lastB, 1));
      @(negedge clk);
      check({tag, "_empty_after"}, obs(), pack(0, 0, 1, lastH, lastV, lastR, lastG, lastB, 0));
    end else begin
      for (int y = ay0; y <= cy1; y++)
        for (int x = ax0; x <= cx1; x++) begin
          @(negedge clk);
          check(tag, obs(), pack(1, 1, 0, x * 8, y * 8, r, g, b, x == cx1 && y == cy1));
        end
      lastH = cx1 * 8;
      lastV = cy1 * 8;
      lastR = r;
      lastG = g;
      lastB = b;
      @(negedge clk);
      check({tag, "_idle"}, obs(), pack(0, 0, 1, lastH, lastV, lastR, lastG, lastB, 0));
    end
  endtask
  task automatic runCmd(input string tag, input int ax0, input int ay0, input int ax1,
                        input int ay1, input logic [3:0] r, input logic [3:0] g,
                        input logic [3:0] b);
    acceptCmd(ax0, ay0, ax1, ay1, r, g, b, 1'b0);
    expectCmd(tag, ax0, ay0, ax1, ay1, r, g, b);
  endtask
  initial begin
    int rx0, ry0, rx1, ry1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x0 = '0;
    bus.cmd_y0 = '0;
    bus.cmd_x1 = '0;
    bus.cmd_y1 = '0;
    bus.cmd_r = '0;
    bus.cmd_g = '0;
    bus.cmd_b = '0;
    #12;
    check("reset_idle_zero", zeroView(), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_after_reset", obs(), pack(0, 0, 1, 0, 0, 0, 0, 0, 0));
    runCmd("single", 5, 7, 5, 7, 4'hF, 4'h0, 4'h0);
    runCmd("rect2x3", 2, 3, 4, 4, 4'h3, 4'hA, 4'h5);
    runCmd("full_clip", 0, 0, 127, 127, 4'h1, 4'h2, 4'h3);
    runCmd("empty", 10, 0, 3, 0, 4'h7, 4'h7, 4'h7);
    acceptCmd(1, 1, 3, 2, 4'h9, 4'h8, 4'h7, 1'b1);
    bus.cmd_x0 = 7'd20;
    bus.cmd_y0 = 7'd30;
    bus.cmd_x1 = 7'd22;
    bus.cmd_y1 = 7'd31;
    bus.cmd_r = 4'h1;
    bus.cmd_g = 4'hE;
    bus.cmd_b = 4'h6;
    expectCmd("busy_first", 1, 1, 3, 2, 4'h9, 4'h8, 4'h7);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    expectCmd("busy_second", 20, 30, 22, 31, 4'h1, 4'hE, 4'h6);
    for (int n = 0; n < 40; n++) begin
      rx0 = $urandom_range(0, 110);
      rx1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : rx0 + $urandom_range(0, 6);
      ry0 = $urandom_range(0, 80);
      ry1 = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 80) : ry0 + $urandom_range(0, 3);
      if (rx1 > 127) rx1 = 127;
      if (ry1 > 127) ry1 = 127;
      runCmd("random", rx0, ry0, rx1, ry1, 4'($urandom), 4'($urandom), 4'($urandom));
    end
    acceptCmd(0, 0, 20, 20, 4'hC, 4'hC, 4'hC, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("reset_midfill_zero", zeroView(), 0);
    lastH = 0;
    lastV = 0;
    lastR = '0;
    lastG = '0;
    lastB = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("after_abort", obs(), pack(0, 0, 1, 0, 0, 0, 0, 0, 0));
    end
    runCmd("post_abort", 98, 73, 99, 74, 4'h5, 4'h6, 4'h7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
